// File: rtl/joy_dir_resolver.sv
// -----------------------------------------------------------------------------
// joy_dir_resolver
//
// Per-player joystick direction conditioner. For every player the four
// direction bits {U,D,L,R} are synchronised, optionally debounced, and then
// opposing presses on each axis are resolved with a selectable SOCD policy.
// An optional 4-way restriction removes diagonals. A one-cycle strobe per
// player flags every change of the resolved output.
//
// Parameters:
//   PLAYERS   number of independent player channels (1..4)
//   DEBOUNCE  stable cycles required before a bit change is accepted (0 = off)
//   CNT_W     debounce counter width, DEBOUNCE < 2**CNT_W
//
// Ports:
//   clk_sys   in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   mode      in   [1:0] SOCD policy: 0 last-wins, 1 neutral, 2 first-wins,
//                  3 passthrough
//   four_way  in   1 = suppress diagonals (ignored in passthrough)
//   dir_in    in   [4*PLAYERS-1:0] raw directions, player p at [4p+3:4p]
//                  = {U,D,L,R}, asynchronous
//   dir_out   out  [4*PLAYERS-1:0] resolved directions, registered
//   changed   out  [PLAYERS-1:0] one-cycle pulse when a player's dir_out moves
// -----------------------------------------------------------------------------
module joy_dir_resolver #(
    parameter int PLAYERS  = 2,
    parameter int DEBOUNCE = 0,
    parameter int CNT_W    = 8
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic                   four_way,
    input  logic [4*PLAYERS-1:0]   dir_in,
    output logic [4*PLAYERS-1:0]   dir_out,
    output logic [PLAYERS-1:0]     changed
);

    localparam int             NBITS   = 4 * PLAYERS;
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE);
    localparam logic           AXIS_H  = 1'b0;
    localparam logic           AXIS_V  = 1'b1;

    // Axis codes: 2'b10 means the "high" bit of the pair (L or U) wins,
    // 2'b01 means the "low" bit (R or D) wins.
    function automatic logic [1:0] last_update(
        input logic [1:0] cur,
        input logic       rise_hi,
        input logic       rise_lo
    );
        logic [1:0] res;
        res = cur;
        if (rise_hi) begin
            res = 2'b10;
        end else if (rise_lo) begin
            res = 2'b01;
        end
        return res;
    endfunction

    function automatic logic [1:0] first_update(
        input logic [1:0] cur,
        input logic       rise_hi,
        input logic       rise_lo,
        input logic       held_hi,
        input logic       held_lo
    );
        logic [1:0] res;
        res = cur;
        if (rise_hi && rise_lo) begin
            res = 2'b10;
        end else if (rise_hi && !held_lo) begin
            res = 2'b10;
        end else if (rise_lo && !held_hi) begin
            res = 2'b01;
        end
        return res;
    endfunction

    function automatic logic [1:0] resolve_axis(
        input logic [1:0] held,
        input logic [1:0] pol,
        input logic [1:0] last_code,
        input logic [1:0] first_code
    );
        logic [1:0] res;
        res = held;
        if (held == 2'b11) begin
            case (pol)
                2'd0:    res = last_code;
                2'd1:    res = 2'b00;
                2'd2:    res = first_code;
                default: res = 2'b11;
            endcase
        end
        return res;
    endfunction

    logic [NBITS-1:0]   sync0_reg;
    logic [NBITS-1:0]   sync1_reg;
    logic [NBITS-1:0]   stable_reg;
    logic [NBITS-1:0]   stable_next;
    logic [NBITS-1:0]   rise;
    logic [NBITS-1:0]   resolved;
    logic [NBITS-1:0]   dir_out_reg;
    logic [PLAYERS-1:0] changed_reg;
    logic [PLAYERS-1:0] changed_next;

    assign rise = stable_next & ~stable_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync0_reg  <= '0;
            sync1_reg  <= '0;
            stable_reg <= '0;
        end else begin
            sync0_reg  <= dir_in;
            sync1_reg  <= sync0_reg;
            stable_reg <= stable_next;
        end
    end

    // Per-bit debounce: a differing sample must persist until the counter
    // reaches DEBOUNCE before it is accepted; any agreement restarts the count.
    genvar gb;
    generate
        for (gb = 0; gb < NBITS; gb++) begin : g_bit
            logic [CNT_W-1:0] cnt_reg;
            logic             differs;

            assign differs         = (sync1_reg[gb] != stable_reg[gb]);
            assign stable_next[gb] = (differs && (cnt_reg == DEB_MAX)) ?
                                     sync1_reg[gb] : stable_reg[gb];

            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (!differs) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DEB_MAX) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < PLAYERS; gi++) begin : g_player
            logic [3:0] s_cur;
            logic [3:0] s_nxt;
            logic [3:0] r_cur;
            logic [1:0] last_h_reg;
            logic [1:0] last_v_reg;
            logic [1:0] first_h_reg;
            logic [1:0] first_v_reg;
            logic       last_axis_reg;
            logic       last_axis_next;
            logic [1:0] res_h;
            logic [1:0] res_v;
            logic [3:0] res_dir;

            assign s_cur = stable_reg[4*gi +: 4];
            assign s_nxt = stable_next[4*gi +: 4];
            assign r_cur = rise[4*gi +: 4];

            // Horizontal uses {L,R} = bits [1:0]; vertical uses {U,D} = [3:2].
            // A horizontal rise dominates when both axes rise together.
            always_comb begin
                last_axis_next = last_axis_reg;
                if (|r_cur[1:0]) begin
                    last_axis_next = AXIS_H;
                end else if (|r_cur[3:2]) begin
                    last_axis_next = AXIS_V;
                end
            end

            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    last_h_reg    <= 2'b00;
                    last_v_reg    <= 2'b00;
                    first_h_reg   <= 2'b00;
                    first_v_reg   <= 2'b00;
                    last_axis_reg <= AXIS_H;
                end else begin
                    last_h_reg    <= last_update(last_h_reg, r_cur[1], r_cur[0]);
                    last_v_reg    <= last_update(last_v_reg, r_cur[3], r_cur[2]);
                    first_h_reg   <= first_update(first_h_reg, r_cur[1], r_cur[0],
                                                  s_nxt[1], s_nxt[0]);
                    first_v_reg   <= first_update(first_v_reg, r_cur[3], r_cur[2],
                                                  s_nxt[3], s_nxt[2]);
                    last_axis_reg <= last_axis_next;
                end
            end

            // Resolution works from the registered stable state so the
            // output lands one edge after s.
            always_comb begin
                res_h = resolve_axis(s_cur[1:0], mode, last_h_reg, first_h_reg);
                res_v = resolve_axis(s_cur[3:2], mode, last_v_reg, first_v_reg);
                if (four_way && (mode != 2'd3) && (|res_h) && (|res_v)) begin
                    if (last_axis_reg == AXIS_V) begin
                        res_h = 2'b00;
                    end else begin
                        res_v = 2'b00;
                    end
                end
                res_dir = {res_v, res_h};
            end

            assign resolved[4*gi +: 4] = res_dir;
            assign changed_next[gi]    = (res_dir != dir_out_reg[4*gi +: 4]);
        end
    endgenerate

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dir_out_reg <= '0;
            changed_reg <= '0;
        end else begin
            dir_out_reg <= resolved;
            changed_reg <= changed_next;
        end
    end

    assign dir_out = dir_out_reg;
    assign changed = changed_reg;

endmodule

// File: tb/tb_joy_dir_resolver.sv
// -----------------------------------------------------------------------------
// tb_joy_dir_resolver
//
// Directed bench for joy_dir_resolver. dut0 is a 2-player instance without
// debouncing, dut4 a 1-player instance with DEBOUNCE=4. Expected outputs are
// queued when stimulus is applied and popped when the DUT is due to answer.
// -----------------------------------------------------------------------------
module tb_joy_dir_resolver;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       four_way;
    logic [7:0] dir_in0;
    logic [7:0] dir_out0;
    logic [1:0] changed0;
    logic [3:0] dir_in4;
    logic [3:0] dir_out4;
    logic [0:0] changed4;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] prev_exp;

    always #5 clk_sys = ~clk_sys;

    joy_dir_resolver #(.PLAYERS(2), .DEBOUNCE(0), .CNT_W(8)) dut0 (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .mode     (mode),
        .four_way (four_way),
        .dir_in   (dir_in0),
        .dir_out  (dir_out0),
        .changed  (changed0)
    );

    joy_dir_resolver #(.PLAYERS(1), .DEBOUNCE(4), .CNT_W(8)) dut4 (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .mode     (mode),
        .four_way (four_way),
        .dir_in   (dir_in4),
        .dir_out  (dir_out4),
        .changed  (changed4)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Called just after a falling edge. The following rising edge is E0; the
    // output must hold until E2 and show the new value after E3, with a
    // single-cycle change strobe on each player whose slice moved.
    task automatic run_step(input string tag, input logic [7:0] din, input logic [7:0] expv);
        logic [7:0] e;
        logic [1:0] exp_chg;
        dir_in0 = din;
        exp_q.push_back(expv);
        repeat (3) @(posedge clk_sys);
        #1;
        chk({tag, "/hold"}, dir_out0, prev_exp);
        @(posedge clk_sys);
        #1;
        e = exp_q.pop_front();
        exp_chg = {(e[7:4] != prev_exp[7:4]), (e[3:0] != prev_exp[3:0])};
        chk({tag, "/dir"}, dir_out0, e);
        chk({tag, "/chg"}, {6'b0, changed0}, {6'b0, exp_chg});
        @(posedge clk_sys);
        #1;
        chk({tag, "/chg_off"}, {6'b0, changed0}, 8'h00);
        $display("step %s: mode=%0d four_way=%0d dir_in=%b dir_out=%b", tag, mode, four_way, din, dir_out0);
        prev_exp = e;
        @(negedge clk_sys);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] e4;
        reset    = 1'b1;
        mode     = 2'd0;
        four_way = 1'b0;
        dir_in0  = 8'h00;
        dir_in4  = 4'h0;
        prev_exp = 8'h00;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("reset/dir0", dir_out0, 8'h00);
        chk("reset/chg0", {6'b0, changed0}, 8'h00);
        chk("reset/dir4", {4'b0, dir_out4}, 8'h00);
        chk("reset/chg4", {7'b0, changed4}, 8'h00);
        $display("step reset: dir_out0=%b dir_out4=%b", dir_out0, dir_out4);
        @(negedge clk_sys);
        reset = 1'b0;

        // last-wins
        mode = 2'd0;
        run_step("m0_R",    8'h01, 8'h01);
        run_step("m0_RL",   8'h03, 8'h02);
        run_step("m0_relL", 8'h01, 8'h01);
        run_step("m0_relR", 8'h00, 8'h00);

        // neutral
        mode = 2'd1;
        run_step("m1_R",    8'h01, 8'h01);
        run_step("m1_RL",   8'h03, 8'h00);
        run_step("m1_relL", 8'h01, 8'h01);
        run_step("m1_relR", 8'h00, 8'h00);

        // first-wins: R held first keeps 0001 until R is released
        mode = 2'd2;
        run_step("m2_R",    8'h01, 8'h01);
        run_step("m2_RL",   8'h03, 8'h01);
        run_step("m2_relR", 8'h02, 8'h02);
        run_step("m2_relL", 8'h00, 8'h00);

        // simultaneous R+L
        mode = 2'd0;
        run_step("sim_m0",     8'h03, 8'h02);
        run_step("sim_m0_rel", 8'h00, 8'h00);
        mode = 2'd2;
        run_step("sim_m2",     8'h03, 8'h02);
        run_step("sim_m2_rel", 8'h00, 8'h00);
        mode = 2'd3;
        run_step("sim_m3",     8'h03, 8'h03);
        run_step("sim_m3_rel", 8'h00, 8'h00);

        // 4-way restriction vs diagonals
        mode     = 2'd0;
        four_way = 1'b1;
        run_step("fw1_R",    8'h01, 8'h01);
        run_step("fw1_RU",   8'h09, 8'h08);
        run_step("fw1_relU", 8'h01, 8'h01);
        run_step("fw1_relR", 8'h00, 8'h00);
        four_way = 1'b0;
        run_step("fw0_R",    8'h01, 8'h01);
        run_step("fw0_RU",   8'h09, 8'h09);
        run_step("fw0_rel",  8'h00, 8'h00);

        // two players, P1 holds U+D, then mid-run reset
        run_step("p1_ud_p0_R",  8'hC1, 8'h81);
        run_step("p1_ud_p0_0",  8'hC0, 8'h80);
        run_step("p1_ud_p0_L",  8'hC2, 8'h82);
        reset = 1'b1;
        @(posedge clk_sys);
        #1;
        chk("midrst/dir0", dir_out0, 8'h00);
        chk("midrst/chg0", {6'b0, changed0}, 8'h00);
        $display("step midrst: dir_out0=%b changed0=%b", dir_out0, changed0);
        @(negedge clk_sys);
        reset    = 1'b0;
        prev_exp = 8'h00;
        run_step("refill",      8'hC2, 8'h82);
        run_step("refill_p0_0", 8'hC0, 8'h80);
        run_step("all_rel",     8'h00, 8'h00);

        // debounce: 3-cycle glitch must be rejected
        dir_in4 = 4'b0001;
        exp_q.push_back(8'h00);
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        dir_in4 = 4'b0000;
        e4 = exp_q.pop_front();
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_sys);
            #1;
            chk("deb_glitch/dir", {4'b0, dir_out4}, e4);
            chk("deb_glitch/chg", {7'b0, changed4}, 8'h00);
        end
        $display("step deb_glitch: dir_out4=%b", dir_out4);
        @(negedge clk_sys);

        // debounce: 10-cycle pulse appears 7 edges after capture
        dir_in4 = 4'b0001;
        exp_q.push_back(8'h01);
        @(posedge clk_sys);               // E0
        repeat (6) @(posedge clk_sys);    // E6
        #1;
        chk("deb_pulse/early", {4'b0, dir_out4}, 8'h00);
        @(posedge clk_sys);               // E7
        #1;
        e4 = exp_q.pop_front();
        chk("deb_pulse/dir", {4'b0, dir_out4}, e4);
        chk("deb_pulse/chg", {7'b0, changed4}, 8'h01);
        $display("step deb_pulse: dir_out4=%b changed4=%b", dir_out4, changed4);
        repeat (2) @(posedge clk_sys);    // E9
        @(negedge clk_sys);
        dir_in4 = 4'b0000;
        exp_q.push_back(8'h00);
        repeat (10) @(posedge clk_sys);
        #1;
        e4 = exp_q.pop_front();
        chk("deb_release/dir", {4'b0, dir_out4}, e4);
        chk("deb_release/chg", {7'b0, changed4}, 8'h00);
        $display("step deb_release: dir_out4=%b", dir_out4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/joy_dir_resolver.md
# joy_dir_resolver

Parametrised per-player joystick direction conditioner. It is the successor to the two-way left/right resolver and sits between the keyboard/USB/DB9 input merge and the core's switch-port mapping. For each player it synchronises and optionally debounces four direction bits, then resolves opposing presses on both axes with a selectable SOCD policy and an optional 4-way restriction. It also emits a one-cycle change strobe per player.

## Interface
- PLAYERS, default 2: number of independent player channels (1..4).
- DEBOUNCE, default 0: stable cycles required before a bit change is accepted; 0 disables debouncing.
- CNT_W, default 8: debounce counter width; must satisfy DEBOUNCE < 2^CNT_W.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  SOCD policy: 0 last-wins, 1 neutral, 2 first-wins, 3 passthrough.
- four_way  in  1  1 = never output diagonals (ignored in mode 3).
- dir_in  in  4*PLAYERS  per player p bits [4p+3:4p] = {U,D,L,R}, active-high, asynchronous.
- dir_out  out  4*PLAYERS  resolved directions, same packing, registered.
- changed  out  PLAYERS  one-cycle pulse when the player's dir_out changes.

## Operation
The pipeline is identical per bit and independent per player.

- sync0 <= dir_in and sync1 <= sync0 form a 2-flop synchroniser.
- Debounce produces a stable register s per bit, with counter cnt per bit:
  - if sync1 == s, cnt <= 0.
  - else if cnt == DEBOUNCE, s <= sync1 and cnt <= 0.
  - else cnt <= cnt+1.
  - With DEBOUNCE=0, s follows sync1 with one edge of delay.
- Press edges: rise = s_next & ~s, evaluated on the same edge s updates.
- Horizontal axis state (vertical is identical with U in place of L and D in place of R):
  - last_h: a rise on R sets 01, a rise on L sets 10; if both rise on the same edge, L (10) wins.
  - first_h: a rise on R sets 01 only if L is not held in s_next; a rise on L sets 10 only if R is not held. If both rise together, it is set to 10.
- Axis resolution, when both bits of the axis are held in s:
  - mode 0 outputs last_h.
  - mode 1 outputs 00.
  - mode 2 outputs first_h.
  - mode 3 outputs 11.
  - When one or zero bits are held, the axis outputs s unchanged.
- last_axis: any rise on L/R sets H; any rise on U/D sets V; if both rise on the same edge, H wins.
- 4-way: if four_way=1, mode≠3, and both resolved axes are non-zero, output only the last_axis axis and zero the other.
- Output register: dir_out <= resolved value. changed[p] <= (new dir_out slice ≠ current dir_out slice).
- mode and four_way are sampled combinationally into the output register. A change takes effect on the next edge, with no state flush.
- Reset clears sync0, sync1, s, cnt, last_h, first_h, last_axis(=H), dir_out and changed to 0.
- Reset asserted mid-operation clears everything on that edge. Held inputs are then re-seen as fresh rises once the pipeline refills.

## Timing
- Latency with DEBOUNCE=0: a dir_in change captured at edge E0 reaches sync1 at E1, s at E2, and dir_out at E3. changed pulses high during the cycle after E3.
- Latency with DEBOUNCE=N: E3+N, provided the input is stable throughout. A glitch shorter than N+1 cycles at sync1 never reaches s.
- changed is high for exactly one cycle per dir_out transition. Back-to-back transitions give back-to-back pulses.
- All outputs are 0 from the first reset edge until the first resolved non-zero input.
- Counter wrap cannot occur because cnt resets on reaching DEBOUNCE.

## Test plan
- DEBOUNCE=0, mode 0, P0:
  - press R, then L 5 cycles later -> dir_out[3:0] goes 0001 then 0010.
  - release L -> 0001.
  - release R -> 0000.
  - Each step is 3 edges after input, with changed[0] pulsing once per step.
- Same sequence in mode 1 -> 0001, 0000, 0001, 0000. In mode 2 -> dir_out stays 0001 until R is released, then 0010.
- R and L asserted on the same cycle, mode 0 -> 0010. Mode 2 -> 0010. Mode 3 -> 0011.
- four_way=1: hold R, then press U -> 1000; release U -> 0001. With four_way=0 the same stimulus -> 1001.
- DEBOUNCE=4:
  - a 3-cycle R pulse -> dir_out stays 0000 and changed stays 0.
  - a 10-cycle pulse -> dir_out 0001 appears 7 edges after capture.
- PLAYERS=2: hold P1 U+D in mode 0 while P0 toggles, then assert reset for 1 cycle -> all outputs 0 on the next edge. After release, P1 = 1000 (U wins simultaneous re-rise) 3 edges later, with P0 unaffected by P1.
